// File: rtl/loss_batch_sched.sv
// Batch loss scheduler: hands samples to an external loss unit one at a time,
// accumulates the returned losses and publishes the truncated mean per batch.
module loss_batch_sched #(
  parameter int BATCH_SIZE     = 8,
  parameter int LOG2_BATCH     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  batch_start,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  loss_start,
  input  logic                  loss_done,
  input  logic [31:0]           loss_value,
  output logic [LOG2_BATCH-1:0] sample_idx,
  output logic [31:0]           batch_loss,
  output logic                  batch_done,
  output logic                  busy,
  output logic                  error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = 32 + LOG2_BATCH;

  typedef enum logic [2:0] {IDLE, WAIT_SAMPLE, LAUNCH, WAIT_LOSS, FINISH} state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [TW-1:0]   cnt;

  // Decoded outputs are registered alongside each transition so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      sample_idx   <= '0;
      batch_loss   <= '0;
      batch_done   <= 1'b0;
      sample_ready <= 1'b0;
      loss_start   <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
    end else begin
      batch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (batch_start) begin
            acc          <= '0;
            sample_idx   <= '0;
            error        <= 1'b0;
            state        <= WAIT_SAMPLE;
            sample_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        WAIT_SAMPLE: begin
          if (sample_valid) begin
            state        <= LAUNCH;
            sample_ready <= 1'b0;
            loss_start   <= 1'b1;
          end
        end
        LAUNCH: begin
          state      <= WAIT_LOSS;
          loss_start <= 1'b0;
          cnt        <= '0;
        end
        WAIT_LOSS: begin
          // A completion in the last allowed cycle beats the timeout.
          if (loss_done) begin
            acc <= acc + {{LOG2_BATCH{1'b0}}, loss_value};
            if (sample_idx == LOG2_BATCH'(BATCH_SIZE - 1)) begin
              state <= FINISH;
            end else begin
              sample_idx   <= sample_idx + 1'b1;
              state        <= WAIT_SAMPLE;
              sample_ready <= 1'b1;
            end
          end else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            error <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          batch_loss <= acc[AW-1:LOG2_BATCH];
          batch_done <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          sample_ready <= 1'b0;
          loss_start   <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
